// File: rtl/physics_pkg.sv
// Shared motion types and stage constants for the character physics blocks.
package physics_pkg;

   typedef enum logic [1:0] {
      GROUNDED = 2'd0,
      AIRBORNE = 2'd1,
      DROPPING = 2'd2
   } motion_state_t;

   typedef logic signed [10:0] coord_t;
   typedef logic signed [5:0]  vel_t;

   localparam int HEIGHT   = 30;
   localparam int WIDTH    = 20;
   localparam int GROUND_Y = 400;

   // Gravity step with downward saturation; upward velocities never clamp.
   function automatic vel_t apply_gravity(input vel_t v, input int g, input int lim);
      int sum;
      sum = int'(v) + g;
      return (sum >= lim) ? vel_t'(lim) : vel_t'(sum);
   endfunction

endpackage

// File: rtl/btn_edge_latch.sv
// Rising-edge detector that holds a press until the frame update consumes it.
module btn_edge_latch (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic consume,
   output logic pending
);

   logic btn_q;
   logic held;
   logic rise;

   assign rise    = btn & ~btn_q;
   assign pending = held | rise;

   // A consume drops everything seen so far, including an edge in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q <= 1'b0;
         held  <= 1'b0;
      end else begin
         btn_q <= btn;
         held  <= consume ? 1'b0 : (held | rise);
      end
   end

endmodule

// File: rtl/vertical_motion_ctrl.sv
// Per-character vertical physics: gravity, jumps, platform landing, drop-through, floor clamp.
// Optional coyote-time grace jump is enabled by defining COYOTE_TIME_EN.
module vertical_motion_ctrl
   import physics_pkg::*;
#(
   parameter int HEIGHT      = physics_pkg::HEIGHT,
   parameter int GRAVITY     = 1,
   parameter int JUMP_VEL    = 12,
   parameter int MAX_FALL    = 10,
   parameter int GROUND_Y    = physics_pkg::GROUND_Y,
   parameter int SPAWN_Y     = 100,
   parameter int MAX_JUMPS   = 2,
   parameter int DROP_FRAMES = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               jump_btn,
   input  logic               down_btn,
   input  logic               touching_platform,
   input  logic signed [10:0] plat_top_y,
   output logic signed [10:0] y_pos,
   output logic signed [10:0] next_y,
   output logic signed [5:0]  vel_y,
   output logic               grounded,
   output logic [1:0]         state
);

   localparam int     JW        = $clog2(MAX_JUMPS + 1);
   localparam int     DW        = $clog2(DROP_FRAMES + 1);
   localparam coord_t BODY      = coord_t'(2 * HEIGHT);
   localparam coord_t FLOOR_TOP = coord_t'(GROUND_Y - 2 * HEIGHT);

   motion_state_t     cur_state, nxt_state;
   coord_t            y_nxt;
   vel_t              vel_nxt;
   logic [JW-1:0]     jumps_left, jumps_nxt;
   logic [DW-1:0]     drop_cnt, drop_nxt;
   logic              jump_pending;
   logic              coyote_ok;
   logic              on_floor;
   logic              hits_floor;
   logic signed [12:0] foot_y;

   btn_edge_latch u_jump_latch (
      .clk     (clk),
      .rst     (rst),
      .btn     (jump_btn),
      .consume (frame_tick),
      .pending (jump_pending)
   );

   assign next_y     = y_pos + coord_t'(vel_y);
   assign foot_y     = 13'(next_y) + 13'(2 * HEIGHT);
   assign hits_floor = (foot_y >= 13'(GROUND_Y));
   assign on_floor   = (y_pos >= FLOOR_TOP);
   assign grounded   = (cur_state == GROUNDED);
   assign state      = cur_state;

`ifdef COYOTE_TIME_EN
   logic [2:0] coyote_cnt, coyote_nxt;

   assign coyote_ok = (coyote_cnt != 3'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         coyote_cnt <= 3'd0;
      else if (frame_tick)
         coyote_cnt <= coyote_nxt;
   end
`else
   assign coyote_ok = 1'b0;
`endif

   // Priority chain evaluated once per frame; jumps win over landing.
   always_comb begin
      nxt_state = cur_state;
      y_nxt     = y_pos;
      vel_nxt   = vel_y;
      jumps_nxt = jumps_left;
      drop_nxt  = drop_cnt;
`ifdef COYOTE_TIME_EN
      coyote_nxt = 3'd0;
`endif
      if (jump_pending && ((jumps_left != '0) || coyote_ok)) begin
         vel_nxt   = vel_t'(-JUMP_VEL);
         nxt_state = AIRBORNE;
         drop_nxt  = '0;
         jumps_nxt = coyote_ok ? JW'(MAX_JUMPS - 1) : (jumps_left - 1'b1);
      end else if ((cur_state == GROUNDED) && touching_platform && down_btn && !on_floor) begin
         nxt_state = DROPPING;
         drop_nxt  = DW'(DROP_FRAMES);
         y_nxt     = y_pos + coord_t'(1);
      end else if (touching_platform && !vel_y[5] && (cur_state != DROPPING)) begin
         y_nxt     = plat_top_y - BODY;
         vel_nxt   = '0;
         nxt_state = GROUNDED;
         jumps_nxt = JW'(MAX_JUMPS);
      end else if (hits_floor) begin
         y_nxt     = FLOOR_TOP;
         vel_nxt   = '0;
         nxt_state = GROUNDED;
         jumps_nxt = JW'(MAX_JUMPS);
         drop_nxt  = '0;
      end else begin
         y_nxt   = next_y;
         vel_nxt = apply_gravity(vel_y, GRAVITY, MAX_FALL);
         case (cur_state)
            GROUNDED: begin
               // Walking off an edge spends the ground jump.
               nxt_state = AIRBORNE;
               jumps_nxt = (jumps_left != '0) ? (jumps_left - 1'b1) : jumps_left;
`ifdef COYOTE_TIME_EN
               coyote_nxt = 3'd4;
`endif
            end
            DROPPING: begin
               if (drop_cnt <= DW'(1)) begin
                  nxt_state = AIRBORNE;
                  drop_nxt  = '0;
               end else begin
                  drop_nxt = drop_cnt - 1'b1;
               end
            end
            default: begin
`ifdef COYOTE_TIME_EN
               coyote_nxt = coyote_ok ? (coyote_cnt - 3'd1) : 3'd0;
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state  <= AIRBORNE;
         y_pos      <= coord_t'(SPAWN_Y);
         vel_y      <= '0;
         jumps_left <= JW'(MAX_JUMPS);
         drop_cnt   <= '0;
      end else if (frame_tick) begin
         cur_state  <= nxt_state;
         y_pos      <= y_nxt;
         vel_y      <= vel_nxt;
         jumps_left <= jumps_nxt;
         drop_cnt   <= drop_nxt;
      end
   end

endmodule

// File: doc/vertical_motion_ctrl.md
Name: vertical_motion_ctrl

Overview:
Per-character vertical physics engine and the producer side of the platform-collision interface.
- Owns registered y_pos and vertical velocity.
- Presents y_pos/next_y to the platform collision checkers and consumes their OR'd touching_platform verdict.
- Applies gravity, jumps, landing snap, floor clamp and drop-through once per frame.
- Sits between input decode and the sprite renderer.

Parameters:
HEIGHT, 30, half sprite height in pixels (bottom edge = y_pos + 2*HEIGHT)
GRAVITY, 1, velocity increment per frame (px/frame^2)
JUMP_VEL, 12, jump velocity magnitude; applied as -JUMP_VEL
MAX_FALL, 10, downward velocity saturation
GROUND_Y, 400, stage floor Y (bottom edge clamp)
SPAWN_Y, 100, y_pos after reset
MAX_JUMPS, 2, jumps available per landing (ground jump + air jumps)
DROP_FRAMES, 8, frames platform collisions are ignored after drop-through

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
frame_tick  in  1  one-cycle pulse per video frame; all motion updates occur on it
jump_btn  in  1  raw level, already synchronised
down_btn  in  1  raw level, already synchronised
touching_platform  in  1  OR of platform collision checks evaluated on y_pos/next_y
plat_top_y  in  11 signed  top Y of the platform being touched
y_pos  out  11 signed  registered current Y
next_y  out  11 signed  combinational y_pos + vel_y
vel_y  out  6 signed  registered velocity; positive = down
grounded  out  1  high in GROUNDED state
state  out  2  motion state encoding (physics_pkg)

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-high.
- Reset values: y_pos=SPAWN_Y, vel_y=0, state=AIRBORNE, grounded=0, jumps_left=MAX_JUMPS, drop_cnt=0, jump latch cleared.
- Reset mid-frame aborts any motion; no update until the next frame_tick after release.

Jump latch:
- A rising edge of jump_btn is detected every cycle and latched until consumed at the next frame_tick.
- Multiple edges within one frame count as one press.

States: GROUNDED, AIRBORNE, DROPPING.

Per frame_tick, evaluated in priority order:
1. Jump pending and jumps_left>0:
   - vel_y <= -JUMP_VEL, y_pos <= y_pos (the new velocity applies from the next frame).
   - jumps_left decrements; state <= AIRBORNE; latch cleared.
   - This beats a simultaneous landing.
2. GROUNDED on a platform with down_btn=1:
   - state <= DROPPING, drop_cnt <= DROP_FRAMES.
   - y_pos <= y_pos+1 so the sprite leaves the platform top.
3. touching_platform=1, vel_y>=0, state!=DROPPING:
   - y_pos <= plat_top_y - 2*HEIGHT, vel_y <= 0.
   - state <= GROUNDED, jumps_left <= MAX_JUMPS.
4. next_y + 2*HEIGHT >= GROUND_Y:
   - y_pos <= GROUND_Y - 2*HEIGHT, vel_y <= 0, GROUNDED, jumps refilled.
   - down_btn on the floor is ignored.
5. Otherwise:
   - y_pos <= next_y, vel_y <= min(vel_y+GRAVITY, MAX_FALL).
   - GROUNDED with no support (touching_platform=0 and not on the floor) -> AIRBORNE.

Additional rules:
- DROPPING: drop_cnt decrements each tick and touching_platform is ignored; at 0 -> AIRBORNE.
- A jump press while latched but jumps_left==0 is discarded at the tick.
- Arithmetic: 11-bit signed; vel_y is sign-extended before the add. Velocity saturates; no wrap.
- Between ticks all registers hold. next_y is valid every cycle.

Optional Feature:
COYOTE_TIME_EN
- Defined: on GROUNDED->AIRBORNE without a jump, a 3-bit counter loads 4. A press while the counter>0 performs a ground jump and restores jumps_left=MAX_JUMPS-1 before decrement. The counter decrements per tick.
- Undefined: the counter is absent; walking off an edge consumes the ground jump, so jumps_left = MAX_JUMPS-1 on leaving the edge.

Decomposition:
- physics_pkg: motion_state_t enum (GROUNDED=0, AIRBORNE=1, DROPPING=2), shared HEIGHT/WIDTH/GROUND_Y constants, and the signed coordinate typedef coord_t (logic signed [10:0]).
- One sub-module: btn_edge_latch (rising-edge detect, hold until cleared by frame_tick consume).

Test Plan:
- Reset, then 3 ticks with no input: y_pos 100->100->101->103, vel_y 1,2,3.
- Free fall from y=100: vel_y saturates at 10; y_pos reaches 340, GROUNDED, vel_y=0, never below 340.
- GROUNDED at 340, jump press mid-frame: next tick vel_y=-12, AIRBORNE; second press in air gives vel_y=-12 again; third press is ignored.
- Falling with touching_platform=1, plat_top_y=215, vel_y=4: y_pos snaps to 155, GROUNDED. Same with vel_y=-3: no snap, passes upward.
- GROUNDED at 155, down_btn: DROPPING for 8 ticks, touching_platform ignored, then AIRBORNE; lands at 340.
- Assert rst mid-jump (y=250, vel=-5): immediately y_pos=100, vel_y=0, AIRBORNE; with COYOTE_TIME_EN, a press 3 ticks after walking off an edge jumps with jumps_left=1 remaining.
